// File: rtl/c_damq_pkg.sv
// Shared constants and helpers for the DAMQ tracker.
// Error bit positions within each queue's 2-bit error field.
package c_damq_pkg;

    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_OVERFLOW  = 1;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        for (int i = 0; i < 32; i++) begin
            if (v > 0) begin
                r = r + 1;
                v = v >>> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/c_damq_queue_counter.sv
// Per-queue occupancy counter with legality and error decode.
// Shared-pool bookkeeping is reported upward as consume/rls strobes.
module c_damq_queue_counter
    import c_damq_pkg::*;
#(
    parameter int cw            = 5,
    parameter int num_reserved  = 1,
    parameter int enable_bypass = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          active,
    input  logic          push,
    input  logic          pop,
    input  logic          full,
    output logic [cw-1:0] occ,
    output logic          push_ok,
    output logic          pop_ok,
    output logic          consume,
    output logic          rls,
    output logic [1:0]    errors
);

    logic empty;
    logic bypass;
    logic above_rsv;
    logic at_rsv;

    assign empty  = (occ == '0);
    assign bypass = (enable_bypass != 0) && push;

    assign errors[ERR_OVERFLOW]  = push && full;
    assign errors[ERR_UNDERFLOW] = pop && empty && !bypass;

    assign push_ok = push && !full;
    // An empty-queue pop is only honoured when a real push feeds it.
    assign pop_ok  = pop && (!empty || ((enable_bypass != 0) && push_ok));

    assign at_rsv    = (int'(occ) >= num_reserved);
    assign above_rsv = (int'(occ) > num_reserved);

    assign consume = push_ok && !pop_ok && at_rsv;
    assign rls     = pop_ok && !push_ok && above_rsv;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= '0;
        end else if (active) begin
            if (push_ok && !pop_ok)
                occ <= occ + 1'b1;
            else if (pop_ok && !push_ok)
                occ <= occ - 1'b1;
        end
    end

endmodule

// File: rtl/c_damq_tracker_rsv.sv
// DAMQ buffer-state tracker with per-queue reservations and cap.
// Holds the shared-pool usage and decodes per-queue credit flags.
module c_damq_tracker_rsv
    import c_damq_pkg::*;
#(
    parameter int num_queues      = 4,
    parameter int num_slots       = 32,
    parameter int num_reserved    = 1,
    parameter int max_queue_slots = num_slots,
    parameter int enable_bypass   = 0,
    localparam int CW = clog2(num_slots + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     active,
    input  logic                     push_valid,
    input  logic [num_queues-1:0]    push_sel_qu,
    input  logic                     pop_valid,
    input  logic [num_queues-1:0]    pop_sel_qu,
    output logic [num_queues*CW-1:0] occupancy_qu,
    output logic [CW-1:0]            shared_free,
    output logic [num_queues-1:0]    almost_empty_qu,
    output logic [num_queues-1:0]    empty_qu,
    output logic [num_queues-1:0]    full_qu,
    output logic [num_queues-1:0]    almost_full_qu,
    output logic [num_queues-1:0]    two_free_qu,
    output logic [2*num_queues-1:0]  errors_qu
);

    localparam int S   = num_slots - num_queues * num_reserved;
    localparam int RS  = num_reserved + S;
    localparam int CAP = (max_queue_slots < RS) ? max_queue_slots : RS;

    logic [CW-1:0]         shared_used;
    logic [CW-1:0]         occ     [num_queues];
    logic [CW-1:0]         free_q  [num_queues];
    logic [num_queues-1:0] consume;
    logic [num_queues-1:0] rls;
    logic [num_queues-1:0] push_ok;
    logic [num_queues-1:0] pop_ok;
    int                    n_cons;
    int                    n_rel;

    function automatic logic [CW-1:0] calc_free(
        input logic [CW-1:0] o,
        input logic [CW-1:0] su
    );
        int cap_left;
        int rsv_left;
        int f;
        cap_left = CAP - int'(o);
        rsv_left = num_reserved - int'(o);
        if (rsv_left < 0)
            rsv_left = 0;
        f = rsv_left + (S - int'(su));
        if (cap_left < f)
            f = cap_left;
        if (f < 0)
            f = 0;
        return CW'(f);
    endfunction

    for (genvar q = 0; q < num_queues; q++) begin : g_q
        c_damq_queue_counter #(
            .cw            (CW),
            .num_reserved  (num_reserved),
            .enable_bypass (enable_bypass)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .active  (active),
            .push    (push_valid && push_sel_qu[q]),
            .pop     (pop_valid && pop_sel_qu[q]),
            .full    (full_qu[q]),
            .occ     (occ[q]),
            .push_ok (push_ok[q]),
            .pop_ok  (pop_ok[q]),
            .consume (consume[q]),
            .rls     (rls[q]),
            .errors  (errors_qu[2*q +: 2])
        );

        assign free_q[q] = calc_free(occ[q], shared_used);
        assign occupancy_qu[q*CW +: CW] = occ[q];
        assign empty_qu[q]        = (occ[q] == '0);
        assign almost_empty_qu[q] = (occ[q] == CW'(1));
        assign full_qu[q]         = (free_q[q] == '0);
        assign almost_full_qu[q]  = (free_q[q] == CW'(1));
        assign two_free_qu[q]     = (free_q[q] >= CW'(2));
    end

    always_comb begin
        n_cons = 0;
        n_rel  = 0;
        for (int q = 0; q < num_queues; q++) begin
            n_cons = n_cons + int'(consume[q]);
            n_rel  = n_rel + int'(rls[q]);
        end
    end

    assign shared_free = CW'(S - int'(shared_used));

    always_ff @(posedge clk) begin
        if (reset)
            shared_used <= '0;
        else if (active)
            shared_used <= CW'(int'(shared_used) + n_cons - n_rel);
    end

endmodule

// File: tb/tb_c_damq_tracker_rsv.sv
// Directed bench for c_damq_tracker_rsv (4 queues, 16 slots, 2 reserved, cap 10).
// Two instances differ only in bypass to cover both empty-queue behaviours.
module tb_c_damq_tracker_rsv;

    localparam int NQ = 4;
    localparam int CW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            active;
    logic            push_valid;
    logic [NQ-1:0]   push_sel_qu;
    logic            pop_valid;
    logic [NQ-1:0]   pop_sel_qu;

    logic [NQ*CW-1:0] occ_a,  occ_b;
    logic [CW-1:0]    sf_a,   sf_b;
    logic [NQ-1:0]    ae_a,   ae_b;
    logic [NQ-1:0]    em_a,   em_b;
    logic [NQ-1:0]    fu_a,   fu_b;
    logic [NQ-1:0]    af_a,   af_b;
    logic [NQ-1:0]    tf_a,   tf_b;
    logic [2*NQ-1:0]  er_a,   er_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    c_damq_tracker_rsv #(
        .num_queues(4), .num_slots(16), .num_reserved(2),
        .max_queue_slots(10), .enable_bypass(0)
    ) dut (
        .clk(clk), .reset(reset), .active(active),
        .push_valid(push_valid), .push_sel_qu(push_sel_qu),
        .pop_valid(pop_valid), .pop_sel_qu(pop_sel_qu),
        .occupancy_qu(occ_a), .shared_free(sf_a),
        .almost_empty_qu(ae_a), .empty_qu(em_a),
        .full_qu(fu_a), .almost_full_qu(af_a),
        .two_free_qu(tf_a), .errors_qu(er_a)
    );

    c_damq_tracker_rsv #(
        .num_queues(4), .num_slots(16), .num_reserved(2),
        .max_queue_slots(10), .enable_bypass(1)
    ) dut_bp (
        .clk(clk), .reset(reset), .active(active),
        .push_valid(push_valid), .push_sel_qu(push_sel_qu),
        .pop_valid(pop_valid), .pop_sel_qu(pop_sel_qu),
        .occupancy_qu(occ_b), .shared_free(sf_b),
        .almost_empty_qu(ae_b), .empty_qu(em_b),
        .full_qu(fu_b), .almost_full_qu(af_b),
        .two_free_qu(tf_b), .errors_qu(er_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int occ_of(input logic [NQ*CW-1:0] v, input int q);
        return int'(v[q*CW +: CW]);
    endfunction

    task automatic drive(input logic pv, input logic [NQ-1:0] ps,
                         input logic qv, input logic [NQ-1:0] qs);
        push_valid  = pv;
        push_sel_qu = ps;
        pop_valid   = qv;
        pop_sel_qu  = qs;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic push_n(input int q, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, NQ'(1 << q), 1'b0, '0);
            step();
        end
        idle();
    endtask

    task automatic pop_n(input int q, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b1, NQ'(1 << q));
            step();
        end
        idle();
    endtask

    initial begin
        reset  = 1'b1;
        active = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        #1;

        for (int q = 0; q < NQ; q++)
            check($sformatf("rst_occ%0d", q), occ_of(occ_a, q), 0);
        check("rst_sf", int'(sf_a), 8);
        check("rst_empty", int'(em_a), 4'hf);
        check("rst_aempty", int'(ae_a), 0);
        check("rst_two_free", int'(tf_a), 4'hf);
        check("rst_full", int'(fu_a), 0);
        check("rst_afull", int'(af_a), 0);
        check("rst_err", int'(er_a), 0);

        push_n(0, 1);
        check("q0_aempty", int'(ae_a), 4'h1);
        push_n(0, 8);
        check("q0_occ9", occ_of(occ_a, 0), 9);
        check("q0_afull9", int'(af_a), 4'h1);
        check("sf_at9", int'(sf_a), 1);
        push_n(0, 1);
        check("q0_occ10", occ_of(occ_a, 0), 10);
        check("full_q0", int'(fu_a), 4'h1);
        check("sf_0", int'(sf_a), 0);
        check("two_free_rest", int'(tf_a), 4'he);
        check("afull_rest", int'(af_a), 0);
        check("q1_occ0", occ_of(occ_a, 1), 0);
        push_n(1, 2);
        check("full_q1", int'(fu_a), 4'h3);
        check("q1_occ2", occ_of(occ_a, 1), 2);

        drive(1'b1, 4'h1, 1'b1, 4'h1);
        #1;
        check("ovf_err", int'(er_a), 8'h02);
        step();
        idle();
        #1;
        check("ovf_occ0", occ_of(occ_a, 0), 9);
        check("ovf_sf", int'(sf_a), 1);
        check("idle_err", int'(er_a), 0);

        pop_n(1, 2);
        pop_n(0, 6);
        push_n(2, 2);
        check("pre_q0", occ_of(occ_a, 0), 3);
        check("pre_q2", occ_of(occ_a, 2), 2);
        check("pre_sf", int'(sf_a), 7);
        drive(1'b1, 4'h4, 1'b1, 4'h1);
        #1;
        check("xq_err", int'(er_a), 0);
        step();
        idle();
        #1;
        check("xq_q0", occ_of(occ_a, 0), 2);
        check("xq_q2", occ_of(occ_a, 2), 3);
        check("xq_sf", int'(sf_a), 7);

        drive(1'b1, 4'h8, 1'b1, 4'h8);
        #1;
        check("nobp_err", int'(er_a), 8'h40);
        check("bp_err", int'(er_b), 0);
        step();
        idle();
        #1;
        check("nobp_occ3", occ_of(occ_a, 3), 1);
        check("bp_occ3", occ_of(occ_b, 3), 0);
        check("bp_empty3", int'(em_b[3]), 1);

        active = 1'b0;
        drive(1'b1, 4'h1, 1'b1, 4'h2);
        #1;
        check("inact_udf", int'(er_a), 8'h04);
        step();
        drive(1'b1, 4'h1, 1'b0, '0);
        step();
        check("inact_q0", occ_of(occ_a, 0), 2);
        check("inact_sf", int'(sf_a), 7);
        active = 1'b1;

        reset = 1'b1;
        drive(1'b1, 4'h2, 1'b0, '0);
        step();
        reset = 1'b0;
        idle();
        #1;
        for (int q = 0; q < NQ; q++) begin
            check($sformatf("rr_occ%0d", q), occ_of(occ_a, q), 0);
            check($sformatf("rr_bp_occ%0d", q), occ_of(occ_b, q), 0);
        end
        check("rr_sf", int'(sf_a), 8);
        check("rr_bp_sf", int'(sf_b), 8);
        check("rr_empty", int'(em_a), 4'hf);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
